// File: rtl/a2g_ctrl_sequencer_if.sv
// rtl/a2g_ctrl_sequencer_if.sv - control word in, datapath controls and status word out
// The register side drives ctrl_word and sync_in; the sequencer drives the rest.
interface a2g_ctrl_sequencer_if;
    logic [31:0] ctrl_word;
    logic        sync_in;
    logic        dp_rst;
    logic        dp_en;
    logic        busy;
    logic [31:0] status_word;

    modport master (
        output ctrl_word,
        output sync_in,
        input  dp_rst,
        input  dp_en,
        input  busy,
        input  status_word
    );

    modport slave (
        input  ctrl_word,
        input  sync_in,
        output dp_rst,
        output dp_en,
        output busy,
        output status_word
    );
endinterface

// File: rtl/a2g_ctrl_sequencer.sv
// rtl/a2g_ctrl_sequencer.sv - a2g datapath bring-up sequencer: reset pulse, settle, optional sync wait, run
// Define A2G_SEQ_RSTCNT_EN to build the saturating RESET-entry counter in status_word[31:16].
module a2g_ctrl_sequencer #(
    parameter int RST_MIN       = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int SYNC_TIMEOUT  = 1048576
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    a2g_ctrl_sequencer_if.slave  seq
);
    localparam int               CNT_W       = ($clog2(SYNC_TIMEOUT) > 16) ? $clog2(SYNC_TIMEOUT) : 16;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [7:0]       RST_MIN_B   = 8'(RST_MIN);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] len_last;
    logic [7:0]       len_q, len_n, len_req;
    logic             sync_seen_q, sync_seen_n;
    logic             start_q, clr_q;
    logic             start_edge, clr_edge, enter_reset;
    logic [15:0]      rst_cnt_n;
    logic             unused_ctrl;

    assign start_edge  = seq.ctrl_word[0] & ~start_q;
    assign clr_edge    = seq.ctrl_word[3] & ~clr_q;
    assign len_req     = (seq.ctrl_word[15:8] < RST_MIN_B) ? RST_MIN_B : seq.ctrl_word[15:8];
    assign len_last    = {{(CNT_W-8){1'b0}}, len_q - 8'd1};
    assign unused_ctrl = ^{seq.ctrl_word[31:16], seq.ctrl_word[7:4]};

    // FAULT is left only through fault_clr; any other state except IDLE treats start as abort-and-rerun.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        len_n       = len_q;
        sync_seen_n = sync_seen_q;
        enter_reset = 1'b0;
        if (state_q == ST_FAULT) begin
            if (clr_edge) begin
                state_n     = ST_IDLE;
                sync_seen_n = 1'b0;
                cnt_n       = '0;
            end
        end else if (start_edge) begin
            state_n     = ST_RESET;
            len_n       = len_req;
            cnt_n       = '0;
            sync_seen_n = 1'b0;
            enter_reset = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RESET: begin
                    if (cnt_q == len_last) begin
                        state_n = ST_SETTLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_n = seq.ctrl_word[2] ? ST_WAIT_SYNC : ST_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_SYNC: begin
                    // A sync arriving on the last timeout cycle still counts.
                    if (seq.sync_in) begin
                        state_n     = ST_RUN;
                        sync_seen_n = 1'b1;
                        cnt_n       = '0;
                    end else if (cnt_q == SYNC_LAST) begin
                        state_n = ST_FAULT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!seq.ctrl_word[1]) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

`ifdef A2G_SEQ_RSTCNT_EN
    logic [15:0] rst_cnt_q;

    assign rst_cnt_n = (enter_reset && (rst_cnt_q != 16'hFFFF)) ? rst_cnt_q + 16'd1 : rst_cnt_q;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) rst_cnt_q <= 16'd0;
        else             rst_cnt_q <= rst_cnt_n;
    end
`else
    assign rst_cnt_n = 16'd0;
`endif

    // Outputs are decoded from the next state so they change together with the state register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            len_q           <= 8'd0;
            sync_seen_q     <= 1'b0;
            start_q         <= 1'b0;
            clr_q           <= 1'b0;
            seq.dp_rst      <= 1'b1;
            seq.dp_en       <= 1'b0;
            seq.busy        <= 1'b0;
            seq.status_word <= 32'd0;
        end else begin
            state_q         <= state_n;
            cnt_q           <= cnt_n;
            len_q           <= len_n;
            sync_seen_q     <= sync_seen_n;
            start_q         <= seq.ctrl_word[0];
            clr_q           <= seq.ctrl_word[3];
            seq.dp_rst      <= (state_n == ST_RESET) || (state_n == ST_FAULT);
            seq.dp_en       <= (state_n == ST_RUN);
            seq.busy        <= (state_n == ST_RESET) || (state_n == ST_SETTLE) || (state_n == ST_WAIT_SYNC);
            seq.status_word <= {rst_cnt_n, 11'd0, sync_seen_n, state_n == ST_FAULT, state_n};
        end
    end
endmodule

// File: tb/tb_a2g_ctrl_sequencer.sv
// tb/tb_a2g_ctrl_sequencer.sv - scoreboard bench for a2g_ctrl_sequencer state timing and outputs
module tb_a2g_ctrl_sequencer;
    localparam int SETTLE = 64;
    localparam int TMO    = 32;

    typedef struct {
        logic [2:0] st;
        int         dur;
    } seg_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_rstcnt = 0;
    seg_t exp_q[$];

    a2g_ctrl_sequencer_if bus();

    a2g_ctrl_sequencer #(
        .RST_MIN(4),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_TIMEOUT(TMO)
    ) dut (
        .user_clk(clk),
        .user_rst_n(rst_n),
        .seq(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rstcnt_exp();
`ifdef A2G_SEQ_RSTCNT_EN
        return 32'(exp_rstcnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (bus.status_word[2:0] != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {29'd0, bus.status_word[2:0]}, {29'd0, st});
    endtask

    task automatic pulse_start(input logic [31:0] word);
        bus.ctrl_word = word | 32'd1;
        @(negedge clk);
        bus.ctrl_word[0] = 1'b0;
    endtask

    task automatic push_seq(input int len, input bit arm, input int wait_len);
        exp_q.push_back('{3'd1, len});
        exp_q.push_back('{3'd2, SETTLE});
        if (arm) exp_q.push_back('{3'd3, wait_len});
    endtask

    task automatic end_segment(input logic [2:0] st, input int dur, input bit ok);
        seg_t e;
        if (exp_q.size() == 0) begin
            chk("seg_unexpected", {29'd0, st}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("seg_state", {29'd0, st}, {29'd0, e.st});
            chk("seg_len", dur, e.dur);
            chk("seg_outputs", {31'd0, ok}, 32'd1);
        end
    endtask

    // Monitor: closes each RESET/SETTLE/WAIT_SYNC segment and scores it against the queue.
    initial begin
        logic [2:0] cur_st, st;
        int         cur_dur;
        bit         seg_ok;
        cur_st  = 3'd0;
        cur_dur = 0;
        seg_ok  = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_st  = 3'd0;
                cur_dur = 0;
                seg_ok  = 1'b1;
            end else begin
                st = bus.status_word[2:0];
                if (st != cur_st) begin
                    if (cur_st inside {3'd1, 3'd2, 3'd3}) end_segment(cur_st, cur_dur, seg_ok);
                    cur_st  = st;
                    cur_dur = 0;
                    seg_ok  = 1'b1;
                end
                cur_dur++;
                if (bus.dp_rst !== (st == 3'd1 || st == 3'd5) || bus.dp_en !== (st == 3'd4) ||
                    bus.busy !== (st inside {3'd1, 3'd2, 3'd3}) || bus.status_word[3] !== (st == 3'd5))
                    seg_ok = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ctrl_word = 32'd0;
        bus.sync_in   = 1'b0;
        #2 rst_n = 1'b0;
        tick(5);
        chk("rst_dp_rst", {31'd0, bus.dp_rst}, 32'd1);
        chk("rst_dp_en", {31'd0, bus.dp_en}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_status", bus.status_word, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_dp_rst_hold", {31'd0, bus.dp_rst}, 32'd1);
        tick(1);
        chk("rel_dp_rst_clr", {31'd0, bus.dp_rst}, 32'd0);
        chk("rel_status", bus.status_word, 32'd0);

        // Basic run: len 16, no sync arm.
        push_seq(16, 1'b0, 0);
        pulse_start(32'h0000_1003);
        exp_rstcnt++;
        chk("start_lat_rst", {31'd0, bus.dp_rst}, 32'd1);
        chk("start_lat_state", {29'd0, bus.status_word[2:0]}, 32'd1);
        wait_state(3'd4, 200, "run1_reach");
        chk("run1_dp_en", {31'd0, bus.dp_en}, 32'd1);
        chk("run1_busy", {31'd0, bus.busy}, 32'd0);
        chk("run1_rstcnt", {16'd0, bus.status_word[31:16]}, rstcnt_exp());
        bus.ctrl_word = 32'h0000_1000;
        tick(1);
        chk("hold_drop_state", {29'd0, bus.status_word[2:0]}, 32'd0);
        chk("hold_drop_dp_en", {31'd0, bus.dp_en}, 32'd0);

        // Length clamp, then restart from RUN.
        push_seq(4, 1'b0, 0);
        pulse_start(32'h0000_0203);
        exp_rstcnt++;
        wait_state(3'd4, 200, "run2_reach");
        push_seq(4, 1'b0, 0);
        pulse_start(32'h0000_0203);
        exp_rstcnt++;
        chk("rerun_dp_en", {31'd0, bus.dp_en}, 32'd0);
        chk("rerun_dp_rst", {31'd0, bus.dp_rst}, 32'd1);
        wait_state(3'd4, 200, "rerun_reach");
        bus.ctrl_word = 32'h0000_0000;
        tick(1);
        chk("idle2_state", {29'd0, bus.status_word[2:0]}, 32'd0);

        // Abort during SETTLE after 6 cycles.
        exp_q.push_back('{3'd1, 4});
        pulse_start(32'h0000_0403);
        exp_rstcnt++;
        wait_state(3'd2, 50, "abort_settle_reach");
        tick(5);
        exp_q.push_back('{3'd2, 6});
        push_seq(4, 1'b0, 0);
        pulse_start(32'h0000_0403);
        exp_rstcnt++;
        wait_state(3'd4, 200, "abort_run_reach");
        bus.ctrl_word = 32'h0000_0000;
        tick(1);

        // Sync 10 cycles into WAIT_SYNC.
        push_seq(16, 1'b1, 10);
        pulse_start(32'h0000_1007);
        exp_rstcnt++;
        wait_state(3'd3, 200, "sync_wait_reach");
        tick(9);
        bus.sync_in = 1'b1;
        tick(1);
        bus.sync_in = 1'b0;
        chk("sync_state", {29'd0, bus.status_word[2:0]}, 32'd4);
        chk("sync_dp_en", {31'd0, bus.dp_en}, 32'd1);
        chk("sync_seen", {31'd0, bus.status_word[4]}, 32'd1);
        bus.sync_in = 1'b1;
        tick(1);
        bus.sync_in = 1'b0;
        tick(1);
        chk("sync_in_run_ignored", {29'd0, bus.status_word[2:0]}, 32'd4);
        bus.ctrl_word = 32'h0000_1004;
        tick(1);

        // Sync on the final timeout cycle wins.
        push_seq(16, 1'b1, TMO);
        pulse_start(32'h0000_1007);
        exp_rstcnt++;
        wait_state(3'd3, 200, "late_wait_reach");
        tick(TMO - 1);
        bus.sync_in = 1'b1;
        tick(1);
        bus.sync_in = 1'b0;
        chk("late_sync_state", {29'd0, bus.status_word[2:0]}, 32'd4);
        bus.ctrl_word = 32'h0000_1004;
        tick(1);

        // Timeout into FAULT, ignored start, simultaneous start+clear.
        push_seq(16, 1'b1, TMO);
        pulse_start(32'h0000_1007);
        exp_rstcnt++;
        wait_state(3'd5, 300, "fault_reach");
        chk("fault_bit", {31'd0, bus.status_word[3]}, 32'd1);
        chk("fault_dp_rst", {31'd0, bus.dp_rst}, 32'd1);
        chk("fault_dp_en", {31'd0, bus.dp_en}, 32'd0);
        pulse_start(32'h0000_1007);
        tick(3);
        chk("fault_start_ignored", {29'd0, bus.status_word[2:0]}, 32'd5);
        bus.ctrl_word = 32'h0000_100F;
        tick(1);
        chk("clr_state", {16'd0, bus.status_word[15:0]}, 32'd0);
        chk("clr_rstcnt", {16'd0, bus.status_word[31:16]}, rstcnt_exp());
        tick(3);
        chk("clr_no_restart", {29'd0, bus.status_word[2:0]}, 32'd0);
        chk("clr_dp_rst", {31'd0, bus.dp_rst}, 32'd0);
        bus.ctrl_word = 32'h0000_1002;
        tick(1);

        // Asynchronous reset in the middle of SETTLE.
        exp_q.push_back('{3'd1, 16});
        pulse_start(32'h0000_1003);
        exp_rstcnt++;
        wait_state(3'd2, 50, "mid_settle_reach");
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dp_rst", {31'd0, bus.dp_rst}, 32'd1);
        chk("async_dp_en", {31'd0, bus.dp_en}, 32'd0);
        chk("async_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_status", bus.status_word, 32'd0);
        bus.ctrl_word = 32'd0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_status", bus.status_word, 32'd0);
        chk("post_rst_dp_rst", {31'd0, bus.dp_rst}, 32'd0);
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/a2g_ctrl_sequencer.md
Name: a2g_ctrl_sequencer

Overview:
- Turns the software-written 32-bit a2g control word into a timed, glitch-free datapath bring-up sequence.
- Sequence: reset pulse, then settle, then optional wait for timing sync, then run enable.
- Sits in the user clock domain, between the control-word output of the PPC-to-fabric register and the a2g datapath.
- Exports a status word for a fabric-to-PPC readback register.

Parameters:
- RST_MIN, 4, minimum reset pulse length in cycles; a programmed length below this is raised to RST_MIN.
- SETTLE_CYCLES, 64, cycles to hold the datapath disabled after reset deassertion (1..65535).
- SYNC_TIMEOUT, 1048576, cycles to wait for sync_in before abort to FAULT (≥1).

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  asynchronous active-low reset.
- ctrl_word  in  32  control word from the software register, already synchronous to user_clk. Bit fields:
  - [0] start request, acted on at its rising edge.
  - [1] run_hold: 1 keeps RUN; 0 drops to IDLE.
  - [2] sync_arm: 1 waits for sync_in before RUN.
  - [3] fault_clr, acted on at its rising edge.
  - [15:8] reset length in cycles.
- sync_in  in  1  single-cycle timing sync pulse.
- dp_rst  out  1  active-high datapath reset.
- dp_en  out  1  datapath run enable.
- busy  out  1  high in every state except IDLE, RUN and FAULT.
- status_word  out  32  readback status. Bit fields:
  - [2:0] state code.
  - [3] fault.
  - [4] sync_seen.
  - [31:16] reset counter (optional feature; otherwise 0).

Behaviour:
- Reset (user_rst_n=0, asynchronous): state=IDLE, dp_rst=1, dp_en=0, busy=0, status_word=0, all counters=0, edge-detect history=0.
  - dp_rst deasserts on the first clock after reset release.
- Edge detection: ctrl_word[0] and [3] are registered, so rising edge = current & ~previous. A constantly-high bit never retriggers.
- State codes: IDLE=0, RESET=1, SETTLE=2, WAIT_SYNC=3, RUN=4, FAULT=5.
- IDLE: dp_rst=0, dp_en=0.
  - On a start edge, go to RESET next cycle.
  - Latch len = max(ctrl_word[15:8], RST_MIN).
- RESET: dp_rst=1 for exactly len cycles, counted from the first RESET cycle, then go to SETTLE.
- SETTLE: dp_rst=0, dp_en=0 for exactly SETTLE_CYCLES cycles.
  - Then go to WAIT_SYNC if sync_arm=1, else RUN.
  - sync_arm is sampled on the last SETTLE cycle.
- WAIT_SYNC: timeout counter runs from 0.
  - sync_in=1: go to RUN next cycle and set sync_seen.
  - Counter reaches SYNC_TIMEOUT-1 with no sync: go to FAULT.
  - sync_in on that same final cycle wins and goes to RUN.
- RUN: dp_en=1 is registered and asserts in the first RUN cycle.
  - run_hold=0: go to IDLE next cycle; dp_en=0 from that cycle.
- FAULT: dp_en=0, dp_rst=1, fault=1.
  - Only a fault_clr edge exits, to IDLE, and clears fault and sync_seen.
  - Start edges are ignored while in FAULT.
- Start edge in any state other than IDLE/FAULT (including RUN): restarts at RESET with a freshly latched len, counters cleared, sync_seen cleared.
  - This is the abort-and-rerun path.
- Simultaneous start and fault_clr edges in FAULT: only the clear is taken; the start is ignored and needs a fresh edge.
- sync_in outside WAIT_SYNC is ignored.
- All outputs are registered; no combinational path from inputs to outputs.
- Start edge to dp_rst=1 latency: 1 cycle.

Optional Feature:
- Macro: A2G_SEQ_RSTCNT_EN.
- Defined: 16-bit counter in status_word[31:16].
  - Increments on each entry to RESET.
  - Saturates at 0xFFFF.
  - Cleared only by user_rst_n.
- Undefined: status_word[31:16] is tied to 0 and no counter logic is built.

Test Plan:
1. Reset low 5 cycles, release -> dp_rst=1 during reset, 0 after the first clock; dp_en=0; status_word=0x00000000.
2. ctrl_word=0x0000_1003 (len=16, run_hold=1, arm=0) -> dp_rst high exactly 16 cycles, then 64 cycles SETTLE, then dp_en=1; status[2:0]=4, busy=0. With the feature built, status[31:16]=1.
3. ctrl_word[15:8]=2 with start edge -> dp_rst high exactly 4 cycles (RST_MIN clamp).
4. arm=1, sync_in pulsed 10 cycles into WAIT_SYNC -> dp_en=1 on the following cycle, status[4]=1. Repeat with no sync and SYNC_TIMEOUT=32 -> FAULT after 32 cycles: status[3]=1, dp_rst=1. Then a fault_clr edge -> IDLE, status=0x0 (counter bits aside).
5. In RUN, pulse the start bit again -> dp_en drops and dp_rst rises the next cycle; full sequence reruns. In RUN, run_hold=0 -> IDLE in 1 cycle with dp_en=0.
6. Assert user_rst_n low mid-SETTLE -> outputs go to reset values immediately, without waiting for a clock edge.
